// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port pixel memory arbiter between VGA display fetch and CPU
// Display fetch has absolute priority; CPU accesses fill blanking slots via a 4-state FSM.
module vga_mem_arbiter #(
  parameter int RES_X  = 640,
  parameter int RES_Y  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8:0]        LINE,
  input  logic              inDisplayArea,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pixel,
  output logic              pixel_valid
);

  localparam int                PIXELS    = RES_X * RES_Y;
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIXELS);
  localparam logic [8:0]        LINE_END  = 9'(RES_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] disp_ptr;
  logic [2:0]        fetch_pipe;
  logic [31:0]       rdata_q;
  logic              oor_q;
  logic              cpu_issue;
  logic              cpu_oor;

  assign cpu_issue = !inDisplayArea && (state == IDLE) && cpu_req && !cpu_ack;
  assign cpu_oor   = {1'b0, cpu_addr} >= PIX_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      disp_ptr    <= '0;
      fetch_pipe  <= '0;
      rdata_q     <= '0;
      oor_q       <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      // Memory samples the fetch address one edge later and returns data the edge after;
      // rdata_q realigns that word so it lands on pixel three edges after the fetch.
      fetch_pipe <= {fetch_pipe[1:0], inDisplayArea};
      rdata_q    <= mem_rdata;
      if (fetch_pipe[2]) begin
        pixel       <= rdata_q;
        pixel_valid <= 1'b1;
      end else begin
        pixel       <= '0;
        pixel_valid <= 1'b0;
      end

      if (inDisplayArea) begin
        mem_addr <= disp_ptr;
        mem_we   <= 1'b0;
      end else if (cpu_issue) begin
        mem_addr <= cpu_addr;
        mem_we   <= cpu_we && !cpu_oor;
        if (cpu_we && !cpu_oor) begin
          mem_wdata <= cpu_wdata;
        end
      end else begin
        mem_we <= 1'b0;
      end

      if (LINE >= LINE_END) begin
        disp_ptr <= '0;
      end else if (inDisplayArea) begin
        disp_ptr <= (disp_ptr == LAST_PIX) ? '0 : disp_ptr + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_issue) begin
            state <= ISSUE;
            oor_q <= cpu_oor;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          state     <= ACK;
          cpu_ack   <= 1'b1;
          cpu_rdata <= oor_q ? 32'h0 : mem_rdata;
        end
        ACK: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - directed self-checking bench for vga_mem_arbiter
// Memory model returns the word address for never-written locations, i.e. word[i]=i.
module tb_vga_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [8:0]  line_no;
  logic        ida;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] pixel;
  logic        pixel_valid;

  int n_cmp = 0;
  int n_bad = 0;

  vga_mem_arbiter #(.RES_X(640), .RES_Y(480), .ADDR_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .LINE(line_no), .inDisplayArea(ida),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:524287];
  bit          written [0:524287];

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? mem_arr[mem_addr] : {13'b0, mem_addr};
  end

  function automatic logic [31:0] mem_word(input int a);
    return written[a] ? mem_arr[a] : 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_resync();
    line_no = 9'd480;
    cycle();
    line_no = 9'd0;
  endtask

  task automatic cpu_op(input logic we, input logic [18:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int wcnt,
                        output logic [18:0] waddr);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    rd = '0; lat = 0; wcnt = 0; waddr = '0;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (mem_we) begin
        wcnt++;
        waddr = mem_addr;
      end
      if (cpu_ack) begin
        lat = i;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_wcnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    logic [18:0] waddr;
    int lat, wcnt, first, cnt, err, ack_edge, acks;
    logic [31:0] first_pix;

    vecs[0] = '{1'b1, 19'd5,      32'h00FF0000, 32'h0,        1};
    vecs[1] = '{1'b0, 19'd5,      32'h0,        32'h00FF0000, 0};
    vecs[2] = '{1'b1, 19'd307200, 32'h12345678, 32'h0,        0};
    vecs[3] = '{1'b0, 19'd307200, 32'h0,        32'h0,        0};
    vecs[4] = '{1'b0, 19'd7,      32'h0,        32'h7,        0};
    vecs[5] = '{1'b1, 19'd639,    32'h00123456, 32'h0,        1};
    vecs[6] = '{1'b0, 19'd639,    32'h0,        32'h00123456, 0};
    vecs[7] = '{1'b1, 19'd0,      32'h00C0FFEE, 32'h0,        1};

    rst_n = 1'b0; line_no = '0; ida = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset cpu_ack", 32'(cpu_ack), 32'h0);
    chk("reset pixel", pixel, 32'h0);
    chk("reset pixel_valid", 32'(pixel_valid), 32'h0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Full line of 640 fetches from reset
    ida = 1'b1; first = 0; cnt = 0; err = 0;
    for (int c = 1; c <= 650; c++) begin
      cycle();
      if (c == 640) ida = 1'b0;
      if (pixel_valid) begin
        if (first == 0) first = c;
        if (pixel != 32'(cnt)) err++;
        cnt++;
      end else if (pixel != 32'h0) err++;
    end
    chk("line first pixel edge", 32'(first), 32'd4);
    chk("line pixel count", 32'(cnt), 32'd640);
    chk("line pixel errors", 32'(err), 32'd0);

    // Short frame, vertical blank resync, next frame starts at 0
    frame_resync();
    ida = 1'b1;
    repeat (100) cycle();
    ida = 1'b0;
    chk("frame1 last addr", 32'(mem_addr), 32'd99);
    line_no = 9'd480;
    repeat (2) cycle();
    line_no = 9'd0;
    repeat (4) cycle();
    ida = 1'b1;
    cycle();
    chk("frame2 first addr", 32'(mem_addr), 32'd0);
    cycle();
    chk("frame2 second addr", 32'(mem_addr), 32'd1);
    ida = 1'b0;
    repeat (4) cycle();

    for (int i = 0; i < 8; i++) begin
      cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wcnt, waddr);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d mem_we pulses", i), 32'(wcnt), 32'(vecs[i].exp_wcnt));
      if (vecs[i].exp_wcnt == 1) chk($sformatf("vec%0d we addr", i), 32'(waddr), 32'(vecs[i].addr));
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end

    // CPU read held off by active display until blanking
    frame_resync();
    ida = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd10;
    first = 0; cnt = 0; err = 0; ack_edge = 0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (c == 20) ida = 1'b0;
      if (cpu_ack && ack_edge == 0) begin
        ack_edge = c;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
      if (pixel_valid) begin
        if (first == 0) first = c;
        if (pixel != mem_word(cnt)) err++;
        cnt++;
      end
    end
    cpu_req = 1'b0;
    chk("held ack edge", 32'(ack_edge), 32'd23);
    chk("held rdata", rd, 32'd10);
    chk("held first pixel edge", 32'(first), 32'd4);
    chk("held pixel count", 32'(cnt), 32'd20);
    chk("held pixel errors", 32'(err), 32'd0);

    // CPU accepted on last blank cycle, display starts next edge
    frame_resync();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd5;
    first = 0; cnt = 0; err = 0; ack_edge = 0; rd = '0; first_pix = '0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (c == 1) ida = 1'b1;
      if (c == 4) ida = 1'b0;
      if (cpu_ack && ack_edge == 0) begin
        ack_edge = c;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
      if (pixel_valid) begin
        if (first == 0) begin
          first = c;
          first_pix = pixel;
        end
        if (pixel != mem_word(cnt)) err++;
        cnt++;
      end
    end
    cpu_req = 1'b0;
    chk("overlap ack edge", 32'(ack_edge), 32'd3);
    chk("overlap rdata", rd, 32'h00FF0000);
    chk("overlap first pixel edge", 32'(first), 32'd5);
    chk("overlap pixel0", first_pix, 32'h00C0FFEE);
    chk("overlap pixel count", 32'(cnt), 32'd3);
    chk("overlap pixel errors", 32'(err), 32'd0);

    // Reset in the middle of a write aborts it
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd30; cpu_wdata = 32'h00111111;
    cycle();
    chk("abort mem_we before reset", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we async drop", 32'(mem_we), 32'h0);
    chk("abort mem_addr", 32'(mem_addr), 32'h0);
    cpu_req = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (cpu_ack) acks++;
    end
    chk("abort no ack", 32'(acks), 32'd0);
    cpu_op(1'b0, 19'd30, 32'h0, rd, lat, wcnt, waddr);
    chk("abort write dropped", rd, 32'd30);
    ida = 1'b1;
    cycle();
    chk("post reset first fetch", 32'(mem_addr), 32'd0);
    ida = 1'b0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter RES_X, 640, active pixels per line.
REQ-002 Parameter RES_Y, 480, active lines per frame.
REQ-003 Parameter ADDR_W, 19, pixel-memory word address width; must satisfy 2^ADDR_W >= RES_X*RES_Y.
REQ-004 clk  in  1  pixel clock, 25.175 MHz nominal; all state on rising edge.
REQ-005 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 LINE  in  9  current line from the sync generator.
REQ-007 inDisplayArea  in  1  high while the sync generator is in the active pixel region.
REQ-008 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-009 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-010 cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req is high.
REQ-011 cpu_wdata  in  32  write data, [23:16] R, [15:8] G, [7:0] B, [31:24] ignored.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 cpu_rdata  out  32  read data, valid while cpu_ack is high.
REQ-014 mem_addr  out  ADDR_W  registered single-port memory address.
REQ-015 mem_we  out  1  registered memory write enable.
REQ-016 mem_wdata  out  32  registered memory write data.
REQ-017 mem_rdata  in  32  synchronous memory read data, valid one cycle after the memory samples mem_addr.
REQ-018 pixel  out  32  pixel word to the VGA generator.
REQ-019 pixel_valid  out  1  high when pixel holds fetched display data.

Function
REQ-020 The block shall issue at most one memory access per clock edge by registering mem_addr, mem_we and mem_wdata.
REQ-021 Port priority at each edge shall be: display fetch if inDisplayArea=1; otherwise the CPU issue if the FSM is in IDLE, cpu_req=1 and cpu_ack=0; otherwise an idle slot with mem_we<=0 and mem_addr held.
REQ-022 A display fetch shall set mem_addr<=disp_ptr and mem_we<=0, then increment disp_ptr.
REQ-023 disp_ptr shall wrap from RES_X*RES_Y-1 to 0.
REQ-024 disp_ptr shall be forced to 0 on every edge where LINE >= RES_Y, which resynchronises the fetch pointer every frame.
REQ-025 pixel shall capture mem_rdata 3 edges after the edge at which inDisplayArea=1 was sampled for that fetch, with pixel_valid<=1.
REQ-026 In every other cycle, pixel shall be set to 0 (black) and pixel_valid to 0.
REQ-027 The CPU FSM states shall be IDLE, ISSUE, WAIT and ACK.
REQ-028 IDLE shall go to ISSUE on the edge that issues the CPU access per REQ-021.
REQ-029 ISSUE shall go to WAIT and WAIT shall go to ACK unconditionally.
REQ-030 ACK shall go to IDLE unconditionally.
REQ-031 On the WAIT->ACK edge, cpu_rdata<=mem_rdata and cpu_ack<=1.
REQ-032 cpu_ack shall be high only in ACK; access latency from the accept edge to cpu_ack high is 3 cycles.
REQ-033 A CPU write shall drive mem_we<=1 and mem_wdata<=cpu_wdata for exactly one cycle, on the accept edge only.
REQ-034 A display fetch on the next edge shall not disturb an in-flight CPU access, because the memory has already sampled the CPU address.
REQ-035 A request with cpu_addr >= RES_X*RES_Y shall still complete with cpu_ack.
REQ-036 For such an out-of-range write, mem_we shall stay 0.
REQ-037 For such an out-of-range read, cpu_rdata shall be 0.
REQ-038 cpu_req sampled while cpu_ack=1 shall be ignored, so a new request is accepted no earlier than the cycle after ack.
REQ-039 A pending cpu_req during inDisplayArea=1 shall wait, unbounded, until the next blanking cycle.

Reset
REQ-040 While rst_n=0, the FSM shall be in IDLE and disp_ptr, mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, pixel and pixel_valid shall all be 0.
REQ-041 Reset asserted mid-access shall abort the access without issuing cpu_ack, and mem_we shall drop asynchronously.
REQ-042 After release, the first display fetch shall use address 0.

Verification
REQ-043 Scenario: reset, LINE=0, inDisplayArea high for 640 cycles, memory preloaded word[i]=i -> pixel = 0..639 in order, starting 3 cycles after the first high sample, with pixel_valid high for exactly 640 cycles.
REQ-044 Scenario: inDisplayArea=0, CPU write addr=5 data=0x00FF0000 -> mem_we high one cycle with mem_addr=5, cpu_ack 3 cycles after accept; a following read of addr 5 returns cpu_rdata=0x00FF0000.
REQ-045 Scenario: cpu_req raised while inDisplayArea=1 -> no CPU issue until the first cycle inDisplayArea=0, then ack 3 cycles later, with display pixels unchanged.
REQ-046 Scenario: CPU accepted on the last blanking cycle, inDisplayArea rises next cycle -> both the CPU access and display fetch 0 complete correctly, pixel[0] is correct and cpu_ack fires.
REQ-047 Scenario: write to addr 307200 -> mem_we stays 0 and cpu_ack fires; a read of the same address returns 0.
REQ-048 Scenario: frame 1 drives 100 active pixels then LINE=480 -> disp_ptr=0, and the first fetch of the next frame is address 0.
